// File: rtl/cpu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the cpu_exec_unit datapath.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_LDI = 4'd7,
        OP_MUL = 4'd8
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_FLAGS = 4;
    localparam int FLAG_Z    = 3;
    localparam int FLAG_N    = 2;
    localparam int FLAG_C    = 1;
    localparam int FLAG_V    = 0;

    // Opcode 8 is only legal when the multiplier is built.
    function automatic logic is_legal(input logic [3:0] op, input logic mul_en);
        return (op <= OP_LDI) || (mul_en && (op == OP_MUL));
    endfunction

endpackage

// File: rtl/cpu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks per operation.
// start loads the operands; done is high during the clock whose edge retires the last step.
module cpu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    assign done = (count == CW'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
        end else if (start) begin
            product <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            count   <= CW'(WIDTH);
        end else if (count != '0) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/cpu_exec_unit.sv
// Execution unit: register file, flag-producing ALU and request/response FSM.
// Define CPU_MUL_EN to build the iterative multiplier for opcode 8; otherwise opcode 8 is illegal.
module cpu_exec_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic                  sel_imm,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  wr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] Y,
    output logic [NUM_FLAGS-1:0]  flags,
    output logic                  err,
    output logic                  busy
);

    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int MSB  = DATA_WIDTH - 1;
    localparam int SHW  = $clog2(DATA_WIDTH);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   rf [NREG];

    logic [3:0]              op_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [ADDR_WIDTH-1:0]   rd_q;
    logic                    wr_q;

    logic                    accept;
    logic                    commit;
    logic                    illegal_q;
    logic                    rf_we;
    logic [DATA_WIDTH-1:0]   a_fwd;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [DATA_WIDTH-1:0]   b_fwd;

    logic [DATA_WIDTH-1:0]   alu_y;
    logic                    alu_c;
    logic                    alu_v;
    logic [NUM_FLAGS-1:0]    alu_flags;
    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH:0]     diff;
    logic [DATA_WIDTH:0]     sh_left;
    logic [DATA_WIDTH:0]     sh_right;
    logic [SHW-1:0]          sh_amt;

    logic                    mul_done;
    logic [2*DATA_WIDTH-1:0] mul_prod;

    assign in_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign busy     = (state == ST_MUL);
    assign accept   = in_valid && in_ready;
    assign commit   = (state == ST_DONE);

    // A request accepted on the commit edge sees the value being written at that edge.
    assign a_fwd = (rf_we && (rd_q == rs1)) ? alu_y : rf[rs1];
    assign b_reg = (rf_we && (rd_q == rs2)) ? alu_y : rf[rs2];
    assign b_fwd = sel_imm ? imm : b_reg;

`ifdef CPU_MUL_EN
    localparam logic MUL_EN = 1'b1;

    logic mul_start;
    assign mul_start = accept && (opcode == OP_MUL);

    cpu_mul_seq #(
        .WIDTH(DATA_WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (a_fwd),
        .b      (b_fwd),
        .done   (mul_done),
        .product(mul_prod)
    );
`else
    localparam logic MUL_EN = 1'b0;

    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    assign illegal_q = !is_legal(op_q, MUL_EN);
    assign rf_we     = commit && wr_q && !illegal_q;

    assign sh_amt   = b_q[SHW-1:0];
    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    assign diff     = {1'b0, a_q} - {1'b0, b_q};
    // Extra bit on either side captures the last bit shifted out (zero for a zero shift).
    assign sh_left  = {1'b0, a_q} << sh_amt;
    assign sh_right = {a_q, 1'b0} >> sh_amt;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_y = sum[MSB:0];
                alu_c = sum[DATA_WIDTH];
                alu_v = (a_q[MSB] == b_q[MSB]) && (alu_y[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_y = diff[MSB:0];
                alu_c = diff[DATA_WIDTH];
                alu_v = (a_q[MSB] != b_q[MSB]) && (alu_y[MSB] != a_q[MSB]);
            end
            OP_AND: alu_y = a_q & b_q;
            OP_OR:  alu_y = a_q | b_q;
            OP_XOR: alu_y = a_q ^ b_q;
            OP_SHL: begin
                alu_y = sh_left[MSB:0];
                alu_c = sh_left[DATA_WIDTH];
            end
            OP_SHR: begin
                alu_y = sh_right[DATA_WIDTH:1];
                alu_c = sh_right[0];
            end
            OP_LDI: alu_y = b_q;
            OP_MUL: begin
                if (MUL_EN) begin
                    alu_y = mul_prod[MSB:0];
                    alu_c = |mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_y == '0);
        alu_flags[FLAG_N] = alu_y[MSB];
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    // NOTE: the register file is reset explicitly because reset must clear every register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we) begin
            rf[rd_q] <= alu_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            err       <= 1'b0;
            Y         <= '0;
            flags     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            wr_q      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;

            if (commit) begin
                out_valid <= 1'b1;
                err       <= illegal_q;
                Y         <= alu_y;
                if (!illegal_q) begin
                    flags <= alu_flags;
                end
            end

            if (accept) begin
                op_q <= opcode;
                a_q  <= a_fwd;
                b_q  <= b_fwd;
                rd_q <= rd;
                wr_q <= wr;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state <= (MUL_EN && (opcode == OP_MUL)) ? ST_MUL : ST_DONE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Self-checking bench for cpu_exec_unit (DATA_WIDTH=8, ADDR_WIDTH=4): vector table,
// hand-written corner sequences and randomized ops against an arithmetic reference model.
module tb_cpu_exec_unit;
    import cpu_pkg::*;

`ifdef CPU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       sel_imm;
    logic [7:0] imm;
    logic       wr;
    logic       out_valid;
    logic [7:0] Y;
    logic [3:0] flags;
    logic       err;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_rf [16];
    logic [3:0] m_flags;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        bit         si;
        logic [7:0] exp_y;
        logic [3:0] exp_f;
        int         exp_lat;
    } vec_t;

    vec_t vecs[$];

    cpu_exec_unit #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .sel_imm  (sel_imm),
        .imm      (imm),
        .wr       (wr),
        .out_valid(out_valid),
        .Y        (Y),
        .flags    (flags),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic vec_t mkv(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input bit si, input logic [7:0] ey, input logic [3:0] ef,
                                 input int el);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.si = si; v.exp_y = ey; v.exp_f = ef; v.exp_lat = el;
        return v;
    endfunction

    // Called #1 after a rising edge; issues one request and waits for its response pulse.
    task automatic do_op(input logic [3:0] op, input logic [3:0] rdv, input logic [3:0] rs1v,
                         input logic [3:0] rs2v, input bit si, input logic [7:0] immv,
                         input bit wrv, input int exp_lat,
                         output logic [7:0] y_o, output logic [3:0] f_o, output logic e_o,
                         output int busy_n);
        int waitc;
        int lat;
        waitc = 0;
        while (!in_ready && waitc < 40) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        opcode = op; rd = rdv; rs1 = rs1v; rs2 = rs2v;
        sel_imm = si; imm = immv; wr = wrv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy_n = busy ? 1 : 0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
            if (busy) busy_n++;
        end
        y_o = Y; f_o = flags; e_o = err;
        check("latency", lat, exp_lat);
    endtask

    task automatic readback(input string name, input logic [3:0] r, input logic [7:0] exp);
        logic [7:0] y; logic [3:0] f; logic e; int bn;
        do_op(OP_OR, 4'd0, r, 4'd0, 1'b1, 8'h00, 1'b0, 1, y, f, e, bn);
        check(name, y, exp);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 0;
        m_flags = 4'h0;
    endtask

    // Reference model: evaluates the operation with plain integer arithmetic.
    task automatic model_step(input string tag, input logic [3:0] op, input logic [3:0] rdv,
                              input logic [3:0] rs1v, input logic [3:0] rs2v, input bit si,
                              input logic [7:0] immv, input bit wrv);
        int a, b, r, sa, sb, amt, el, bn;
        bit c, v, e;
        logic [7:0] ey, gy;
        logic [3:0] ef, gf;
        logic ge;
        a = m_rf[rs1v];
        b = si ? int'(immv) : m_rf[rs2v];
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        amt = b % 8;
        r = 0; c = 0; v = 0; e = 0;
        case (op)
            4'd0: begin r = a + b; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin r = a - b; c = (a < b);   v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = a << amt; c = (amt != 0) && (((a >> (8 - amt)) & 1) == 1); end
            4'd6: begin r = a >> amt; c = (amt != 0) && (((a >> (amt - 1)) & 1) == 1); end
            4'd7: r = b;
            4'd8: begin
                if (MUL_EN) begin r = a * b; c = (r > 255); end
                else e = 1;
            end
            default: e = 1;
        endcase
        ey = e ? 8'h00 : 8'(r & 255);
        ef = e ? m_flags : {ey == 8'h00, ey[7], c, v};
        el = (op == 4'd8 && MUL_EN) ? 9 : 1;
        do_op(op, rdv, rs1v, rs2v, si, immv, wrv, el, gy, gf, ge, bn);
        check(tag, {19'd0, ge, gf, gy}, {19'd0, e, ef, ey});
        if (!e) m_flags = ef;
        if (!e && wrv) m_rf[rdv] = int'(ey);
    endtask

    initial begin
        logic [7:0] y;
        logic [3:0] f;
        logic e;
        int bn;
        bit ov_seen;

        // op, a, b, sel_imm, Y, {Z,N,C,V}, latency
        vecs.push_back(mkv(OP_ADD, 8'h03, 8'h05, 0, 8'h08, 4'b0000, 1));
        vecs.push_back(mkv(OP_SUB, 8'h04, 8'h08, 0, 8'hFC, 4'b0110, 1));
        vecs.push_back(mkv(OP_ADD, 8'h7F, 8'h01, 1, 8'h80, 4'b0101, 1));
        vecs.push_back(mkv(OP_ADD, 8'hFF, 8'h01, 0, 8'h00, 4'b1010, 1));
        vecs.push_back(mkv(OP_SUB, 8'h80, 8'h01, 1, 8'h7F, 4'b0001, 1));
        vecs.push_back(mkv(OP_SUB, 8'h05, 8'h05, 0, 8'h00, 4'b1000, 1));
        vecs.push_back(mkv(OP_AND, 8'hF0, 8'h3C, 0, 8'h30, 4'b0000, 1));
        vecs.push_back(mkv(OP_OR,  8'h0F, 8'hF0, 1, 8'hFF, 4'b0100, 1));
        vecs.push_back(mkv(OP_XOR, 8'hAA, 8'hAA, 0, 8'h00, 4'b1000, 1));
        vecs.push_back(mkv(OP_SHL, 8'h81, 8'h01, 1, 8'h02, 4'b0010, 1));
        vecs.push_back(mkv(OP_SHL, 8'hC0, 8'h02, 0, 8'h00, 4'b1010, 1));
        vecs.push_back(mkv(OP_SHL, 8'h81, 8'h00, 1, 8'h81, 4'b0100, 1));
        vecs.push_back(mkv(OP_SHR, 8'h81, 8'h01, 0, 8'h40, 4'b0010, 1));
        vecs.push_back(mkv(OP_SHR, 8'h80, 8'h07, 1, 8'h01, 4'b0000, 1));
        vecs.push_back(mkv(OP_SHR, 8'h83, 8'h09, 0, 8'h41, 4'b0010, 1));
        vecs.push_back(mkv(OP_LDI, 8'h11, 8'h80, 1, 8'h80, 4'b0100, 1));
`ifdef CPU_MUL_EN
        vecs.push_back(mkv(OP_MUL, 8'h08, 8'h04, 0, 8'h20, 4'b0000, 9));
        vecs.push_back(mkv(OP_MUL, 8'h10, 8'h10, 0, 8'h00, 4'b1010, 9));
        vecs.push_back(mkv(OP_MUL, 8'hFF, 8'hFF, 1, 8'h01, 4'b0010, 9));
`endif

        in_valid = 1'b0; opcode = 4'd0; rd = 4'd0; rs1 = 4'd0; rs2 = 4'd0;
        sel_imm = 1'b0; imm = 8'h00; wr = 1'b0;
        do_reset();

        check("rst_Y", Y, 8'h00);
        check("rst_flags", flags, 4'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        for (int r = 0; r < 16; r++) begin
            do_op(OP_ADD, 4'd0, 4'(r), 4'(r), 1'b0, 8'h00, 1'b0, 1, y, f, e, bn);
            check("rst_readback", {e, f, y}, {1'b0, 4'b1000, 8'h00});
        end

        // Back-to-back LDI, LDI, ADD: the ADD's rs2 is written on the edge it is accepted.
        opcode = OP_LDI; rd = 4'd1; sel_imm = 1'b1; imm = 8'd8; wr = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_no_pulse_yet", out_valid, 1'b0);
        opcode = OP_LDI; rd = 4'd2; imm = 8'd4;
        @(posedge clk); #1;
        check("b2b_pulse1", {out_valid, in_ready, Y}, {1'b1, 1'b1, 8'd8});
        opcode = OP_ADD; rd = 4'd3; rs1 = 4'd1; rs2 = 4'd2; sel_imm = 1'b0;
        @(posedge clk); #1;
        check("b2b_pulse2", {out_valid, Y}, {1'b1, 8'd4});
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_pulse3", {out_valid, err, flags, Y}, {1'b1, 1'b0, 4'b0000, 8'd12});
        @(posedge clk); #1;
        check("b2b_idle", {out_valid, in_ready}, {1'b0, 1'b1});
        readback("b2b_rf3", 4'd3, 8'd12);

        do_op(OP_ADD, 4'd3, 4'd3, 4'd0, 1'b1, 8'h01, 1'b0, 1, y, f, e, bn);
        check("nowr_result", {e, f, y}, {1'b0, 4'b0000, 8'd13});
        readback("nowr_rf3", 4'd3, 8'd12);

        do_op(OP_LDI, 4'd4, 4'd0, 4'd0, 1'b1, 8'h80, 1'b1, 1, y, f, e, bn);
        do_op(4'hF, 4'd4, 4'd4, 4'd4, 1'b0, 8'h00, 1'b1, 1, y, f, e, bn);
        check("illegal_op", {e, f, y}, {1'b1, 4'b0100, 8'h00});
        readback("illegal_rf4", 4'd4, 8'h80);

        do_op(OP_LDI, 4'd5, 4'd0, 4'd0, 1'b1, 8'h03, 1'b1, 1, y, f, e, bn);
        do_op(OP_ADD, 4'd5, 4'd5, 4'd5, 1'b0, 8'h00, 1'b1, 1, y, f, e, bn);
        check("same_reg_add", y, 8'd6);
        readback("same_reg_rf5", 4'd5, 8'd6);

`ifdef CPU_MUL_EN
        do_op(OP_LDI, 4'd1, 4'd0, 4'd0, 1'b1, 8'd8, 1'b1, 1, y, f, e, bn);
        do_op(OP_LDI, 4'd2, 4'd0, 4'd0, 1'b1, 8'd4, 1'b1, 1, y, f, e, bn);
        do_op(OP_MUL, 4'd3, 4'd1, 4'd2, 1'b0, 8'h00, 1'b1, 9, y, f, e, bn);
        check("mul_result", {e, f, y}, {1'b0, 4'b0000, 8'd32});
        check("mul_busy_cycles", bn, 8);

        // Reset asserted in the third MUL cycle must abort without a response.
        do_op(OP_LDI, 4'd6, 4'd0, 4'd0, 1'b1, 8'd7, 1'b1, 1, y, f, e, bn);
        do_op(OP_LDI, 4'd7, 4'd0, 4'd0, 1'b1, 8'd9, 1'b1, 1, y, f, e, bn);
        opcode = OP_MUL; rd = 4'd6; rs1 = 4'd6; rs2 = 4'd7; sel_imm = 1'b0; wr = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mulrst_busy", {busy, in_ready}, {1'b1, 1'b0});
        ov_seen = out_valid;
        repeat (2) begin
            @(posedge clk); #1;
            ov_seen |= out_valid;
        end
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            ov_seen |= out_valid;
        end
        reset = 1'b0;
        check("mulrst_state", {busy, in_ready}, {1'b0, 1'b1});
        repeat (12) begin
            @(posedge clk); #1;
            ov_seen |= out_valid;
        end
        check("mulrst_no_valid", ov_seen, 1'b0);
        readback("mulrst_rf6", 4'd6, 8'h00);
`else
        do_op(OP_LDI, 4'd1, 4'd0, 4'd0, 1'b1, 8'h80, 1'b1, 1, y, f, e, bn);
        do_op(OP_MUL, 4'd1, 4'd1, 4'd1, 1'b0, 8'h00, 1'b1, 1, y, f, e, bn);
        check("mul_disabled_err", {e, f, y, busy}, {1'b1, 4'b0100, 8'h00, 1'b0});
        readback("mul_disabled_rf1", 4'd1, 8'h80);
`endif

        foreach (vecs[i]) begin
            do_op(OP_LDI, 4'd1, 4'd0, 4'd0, 1'b1, vecs[i].a, 1'b1, 1, y, f, e, bn);
            do_op(OP_LDI, 4'd2, 4'd0, 4'd0, 1'b1, vecs[i].b, 1'b1, 1, y, f, e, bn);
            do_op(vecs[i].op, 4'd3, 4'd1, 4'd2, vecs[i].si, vecs[i].b, 1'b1,
                  vecs[i].exp_lat, y, f, e, bn);
            check($sformatf("vec%0d", i), {e, f, y}, {1'b0, vecs[i].exp_f, vecs[i].exp_y});
        end

        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 8));
            model_step("rand_op", op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
        end
        for (int r = 0; r < 16; r++) begin
            model_step("final_readback", OP_OR, 4'd0, 4'(r), 4'd0, 1'b1, 8'h00, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
